muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide execution unit sitting between register-file read ports and its write port.
- Consumes the two register read values, computes over DBITS cycles, then issues a one-cycle register write (wrtEn/wrtInd/dIn) back to the register file.
- Asserts busy so the control path stalls fetch/issue while an operation is in flight.

Parameters:
- DBITS, 32, data width; operand and result width.
- ABITS, 4, register index width; must match the register file.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request new operation; sampled only in IDLE.
- op  input  2  00 MUL (low half), 01 MULHU (unsigned high half), 10 DIVU (quotient), 11 REMU (remainder).
- srcA  input  DBITS  operand A (multiplicand / dividend), from read port 0.
- srcB  input  DBITS  operand B (multiplier / divisor), from read port 1.
- dstInd  input  ABITS  destination register index.
- busy  output  1  high while operation in flight (RUN and WB).
- wrtEn  output  1  register-file write enable; one-cycle pulse.
- wrtInd  output  ABITS  register-file write index.
- dOut  output  DBITS  result to register-file data input.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high, named reset.
- States: IDLE, RUN, WB; 2-bit state register, iteration counter of width ceil(log2(DBITS))+1.
- Reset (any time, including mid-operation): state=IDLE, busy=0, wrtEn=0, wrtInd=0, dOut=0, counter=0, operand/accumulator registers=0. An in-flight result is discarded and no write is issued.
- IDLE: if start=1 at a rising edge, latch op, srcA, srcB, dstInd, clear accumulator, load counter=DBITS, go to RUN. Otherwise stay in IDLE.
- RUN: one iteration per cycle, DBITS iterations total.
  - MUL/MULHU: unsigned shift-add over a 2*DBITS-bit product register.
  - DIVU/REMU: restoring division. Each cycle:
    - shift the remainder left and bring in the next dividend bit (MSB first);
    - if remainder >= divisor: subtract and set quotient bit to 1; else set quotient bit to 0.
  - Counter decrements each cycle; when it reaches 0, go to WB.
- WB: exactly one cycle.
  - wrtEn=1, wrtInd=latched dstInd.
  - dOut = product[DBITS-1:0] for MUL, product[2*DBITS-1:DBITS] for MULHU, quotient for DIVU, remainder for REMU.
  - Next state is IDLE.
- Latency: start sampled at edge N; wrtEn is high during the cycle following edge N+DBITS+1 (DBITS RUN cycles plus one WB cycle). Next start is accepted at edge N+DBITS+2 at the earliest.
- busy: high in RUN and WB, low in IDLE; registered output, rises the cycle after start is accepted.
- start while busy=1, including during WB: ignored; no queueing.
- Operand capture: srcA/srcB are used only at the accepting edge. Later changes (e.g. a register-file write to the same register) do not affect the result.
- Divide by zero (srcB=0): no special path; full latency. Restoring division yields quotient = all ones and remainder = srcA.
- dstInd=0 is written normally; the register file has no hardwired zero register.
- Outside WB: wrtEn=0; wrtInd and dOut hold their last WB values.
- All arithmetic is unsigned. Overflow is impossible, since the product register is 2*DBITS wide.

Test Plan:
- Reset, then MUL srcA=7, srcB=6, dstInd=3, start at edge 0 -> busy=1 from edge 1; wrtEn=1 only in the cycle after edge 33, wrtInd=3, dOut=42; busy=0 after edge 34.
- MULHU srcA=0xFFFFFFFF, srcB=0xFFFFFFFF -> dOut=0xFFFFFFFE. Repeat with op=MUL -> dOut=0x00000001.
- DIVU 100/7 -> dOut=14; REMU 100/7 -> dOut=2. DIVU 5/9 -> 0; REMU 5/9 -> 5.
- Divide by zero: DIVU 0x12345678/0 -> dOut=0xFFFFFFFF; REMU same operands -> dOut=0x12345678; latency unchanged.
- Start held high continuously, with operands changed each cycle -> exactly one write every 34 cycles. Each result uses the operands present at its accepting edge; start during WB is ignored.
- Assert reset asynchronously (mid-cycle) at RUN iteration 10 -> busy and wrtEn drop immediately and no write occurs. After release, a new MUL 3*5 produces dOut=15 with normal latency.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Register-file facing bus of the iterative multiply/divide unit: operand and
// index inputs from the read ports, status and write-back outputs to the write port.
interface muldiv_unit_if #(
    parameter int DBITS = 32,
    parameter int ABITS = 4
);
    logic             start;
    logic [1:0]       op;
    logic [DBITS-1:0] srcA;
    logic [DBITS-1:0] srcB;
    logic [ABITS-1:0] dstInd;
    logic             busy;
    logic             wrtEn;
    logic [ABITS-1:0] wrtInd;
    logic [DBITS-1:0] dOut;

    modport master (
        output start, op, srcA, srcB, dstInd,
        input  busy, wrtEn, wrtInd, dOut
    );

    modport slave (
        input  start, op, srcA, srcB, dstInd,
        output busy, wrtEn, wrtInd, dOut
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit: one shift-add or restoring-divide
// step per cycle, followed by a single-cycle register-file write.
module muldiv_unit #(
    parameter int DBITS = 32,
    parameter int ABITS = 4
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(DBITS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        WB   = 2'b10
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [CW-1:0]      count;
    logic [1:0]         op_q;
    logic [DBITS-1:0]   opnd_q;
    logic [ABITS-1:0]   dst_q;
    logic [2*DBITS-1:0] acc;
    logic [2*DBITS-1:0] acc_step;
    logic [DBITS:0]     mul_sum;
    logic [DBITS:0]     rem_shift;
    logic [DBITS-1:0]   rem_sub;
    logic               rem_ge;
    logic [DBITS-1:0]   result;
    logic               busy_q;
    logic               wrt_en_q;
    logic [ABITS-1:0]   wrt_ind_q;
    logic [DBITS-1:0]   dout_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (count == CW'(1)) state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The 2*DBITS accumulator is {product high, multiplier} for multiplies and
    // {partial remainder, dividend/quotient} for divides, so both share one shifter.
    always_comb begin
        mul_sum   = {1'b0, acc[2*DBITS-1:DBITS]} + (acc[0] ? {1'b0, opnd_q} : {(DBITS+1){1'b0}});
        rem_shift = acc[2*DBITS-1:DBITS-1];
        rem_ge    = rem_shift >= {1'b0, opnd_q};
        rem_sub   = rem_shift[DBITS-1:0] - opnd_q;
        if (op_q[1]) begin
            acc_step = {(rem_ge ? rem_sub : rem_shift[DBITS-1:0]), acc[DBITS-2:0], rem_ge};
        end else begin
            acc_step = {mul_sum, acc[DBITS-1:1]};
        end
    end

    // op bit 0 selects the upper half: MULHU high product, REMU remainder.
    assign result = op_q[0] ? acc[2*DBITS-1:DBITS] : acc[DBITS-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            opnd_q <= '0;
            dst_q  <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q   <= bus.op;
                        opnd_q <= bus.op[1] ? bus.srcB : bus.srcA;
                        dst_q  <= bus.dstInd;
                        acc    <= {{DBITS{1'b0}}, (bus.op[1] ? bus.srcA : bus.srcB)};
                        count  <= CW'(DBITS);
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count - CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are registered one stage behind the state so reset clears them at once
    // and wrtInd/dOut keep the last written values between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= 1'b0;
            wrt_en_q  <= 1'b0;
            wrt_ind_q <= '0;
            dout_q    <= '0;
        end else begin
            busy_q   <= (state != IDLE);
            wrt_en_q <= (state == WB);
            if (state == WB) begin
                wrt_ind_q <= dst_q;
                dout_q    <= result;
            end
        end
    end

    assign bus.busy   = busy_q;
    assign bus.wrtEn  = wrt_en_q;
    assign bus.wrtInd = wrt_ind_q;
    assign bus.dOut   = dout_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected writes, a monitor
// pops and compares index, data and write cycle whenever wrtEn is seen.
module tb_muldiv_unit;
    localparam int DBITS = 32;
    localparam int ABITS = 4;
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef struct {
        string      name;
        logic [3:0] ind;
        logic [31:0] data;
        int         cycle;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   edge_cnt;
    exp_t sb[$];

    muldiv_unit_if #(.DBITS(DBITS), .ABITS(ABITS)) bus ();

    muldiv_unit #(.DBITS(DBITS), .ABITS(ABITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    // Presents one operation for a single edge, then scrambles the inputs to
    // confirm the unit only uses the values present at the accepting edge.
    task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [3:0] dst, input logic [31:0] expv,
                                 input bit track, output int acc_edge);
        exp_t e;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.srcA   = a;
        bus.srcB   = b;
        bus.dstInd = dst;
        acc_edge   = edge_cnt + 1;
        if (track) begin
            e.name  = name;
            e.ind   = dst;
            e.data  = expv;
            e.cycle = acc_edge + DBITS + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.start  = 1'b0;
        bus.op     = ~op;
        bus.srcA   = ~a;
        bus.srcB   = b ^ 32'h5A5A_A5A5;
        bus.dstInd = ~dst;
    endtask

    // Leaves the bench one cycle short of the earliest next acceptance edge.
    task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] dst, input logic [31:0] expv);
        int e;
        applyStimulus(name, op, a, b, dst, expv, 1'b1, e);
        repeat (DBITS) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.wrtEn) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write actual ind=%0d data=0x%08h cycle=%0d required no write",
                         bus.wrtInd, bus.dOut, edge_cnt);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_ind"}, 32'(bus.wrtInd), 32'(e.ind));
                checkOutput({e.name, "_data"}, bus.dOut, e.data);
                checkOutput({e.name, "_cycle"}, 32'(edge_cnt), 32'(e.cycle));
            end
        end
    end

    initial begin
        int e;
        int base;
        checks     = 0;
        failures   = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = OP_MUL;
        bus.srcA   = '0;
        bus.srcB   = '0;
        bus.dstInd = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_wrtEn", 32'(bus.wrtEn), 32'd0);
        checkOutput("reset_wrtInd", 32'(bus.wrtInd), 32'd0);
        checkOutput("reset_dOut", bus.dOut, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // First multiply also checks the busy window around the accepting edge.
        applyStimulus("mul_7x6", OP_MUL, 32'd7, 32'd6, 4'd3, 32'd42, 1'b1, e);
        checkOutput("busy_at_accept", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        checkOutput("busy_edge1", 32'(bus.busy), 32'd1);
        repeat (32) @(posedge clk);
        #1;
        checkOutput("busy_edge33", 32'(bus.busy), 32'd1);
        @(posedge clk); #1;
        checkOutput("busy_edge34", 32'(bus.busy), 32'd0);

        runOp("mulhu_ff", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5, 32'hFFFF_FFFE);
        runOp("mul_ff",   OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 32'h0000_0001);
        runOp("divu_100_7", OP_DIVU, 32'd100, 32'd7, 4'd1, 32'd14);
        runOp("remu_100_7", OP_REMU, 32'd100, 32'd7, 4'd2, 32'd2);
        runOp("divu_5_9",   OP_DIVU, 32'd5,   32'd9, 4'd8, 32'd0);
        runOp("remu_5_9",   OP_REMU, 32'd5,   32'd9, 4'd15, 32'd5);
        runOp("divu_by0", OP_DIVU, 32'h1234_5678, 32'd0, 4'd0, 32'hFFFF_FFFF);
        runOp("remu_by0", OP_REMU, 32'h1234_5678, 32'd0, 4'd12, 32'h1234_5678);

        // start held high with operands changing every cycle: accepts every 34 edges.
        @(negedge clk);
        base      = edge_cnt + 1;
        bus.start = 1'b1;
        for (int j = 0; j <= 100; j++) begin
            exp_t x;
            bus.op     = OP_MUL;
            bus.srcA   = 32'(j + 1);
            bus.srcB   = 32'(j + 2);
            bus.dstInd = 4'(j);
            if (j % 34 == 0) begin
                x.name  = $sformatf("held_%0d", j);
                x.ind   = 4'(j);
                x.data  = 32'((j + 1) * (j + 2));
                x.cycle = base + j + DBITS + 1;
                sb.push_back(x);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of RUN iteration 10 aborts the write.
        applyStimulus("aborted", OP_MUL, 32'd11, 32'd13, 4'd9, 32'd143, 1'b0, e);
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_wrtEn", 32'(bus.wrtEn), 32'd0);
        checkOutput("abort_wrtInd", 32'(bus.wrtInd), 32'd0);
        checkOutput("abort_dOut", bus.dOut, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        runOp("mul_3x5", OP_MUL, 32'd3, 32'd5, 4'd7, 32'd15);
        repeat (10) @(negedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
